// File: rtl/sig_pkg.sv
// Shared constants and state type for the signature/halt peripheral.
package sig_pkg;

    localparam logic [31:0] SIG_ADDR_DEF  = 32'h0000_0f00;
    localparam logic [31:0] HALT_ADDR_DEF = 32'hcafe_beef;
    localparam int unsigned DEPTH_DEF     = 8;

    typedef enum logic [1:0] {
        SIG_RUN,
        SIG_DRAIN,
        SIG_HALTED
    } sig_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted only alongside a pop.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullCnt = DEPTH[AW:0];

    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      cnt_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == FullCnt);
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Storage is reset so the head reads zero out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (do_pop && !do_push) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/sig_halt_port.sv
// Store-path signature capture with streaming output and drain-then-halt control.
module sig_halt_port
    import sig_pkg::*;
#(
    parameter logic [31:0] SIG_ADDR  = SIG_ADDR_DEF,
    parameter logic [31:0] HALT_ADDR = HALT_ADDR_DEF,
    parameter int unsigned DEPTH     = DEPTH_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   wr_ni,
    input  logic [31:0]            addr_i,
    input  logic [31:0]            wdata_i,
    output logic                   sig_valid_o,
    input  logic                   sig_ready_i,
    output logic [31:0]            sig_data_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   ovf_o,
    output logic                   halted_o
);

    sig_state_e state_q, state_d;
    logic       ovf_q, ovf_d;
    logic       sig_store, halt_store;
    logic       push_en, fifo_push, fifo_pop, fifo_full, fifo_empty;

    assign sig_store  = !wr_ni && (addr_i == SIG_ADDR);
    assign halt_store = !wr_ni && (addr_i == HALT_ADDR);

    assign sig_valid_o = !fifo_empty;
    assign fifo_pop    = sig_valid_o && sig_ready_i;
    assign fifo_push   = sig_store && push_en;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SIG_RUN;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SIG_RUN:    if (halt_store) state_d = SIG_DRAIN;
            SIG_DRAIN:  if (fifo_empty) state_d = SIG_HALTED;
            SIG_HALTED: state_d = SIG_HALTED;
            default:    state_d = SIG_RUN;
        endcase
    end

    always_comb begin
        push_en  = (state_q == SIG_RUN);
        halted_o = (state_q == SIG_HALTED);
    end

    // Only a push that the FIFO actually rejects counts as an overflow.
    assign ovf_d = ovf_q | (fifo_push && fifo_full && !fifo_pop);
    assign ovf_o = ovf_q;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .wdata_i (wdata_i),
        .pop_i   (fifo_pop),
        .rdata_o (sig_data_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count_o)
    );

endmodule

// File: tb/tb_sig_halt_port.sv
// Scoreboard bench for sig_halt_port: directed plan followed by randomized stores.
module tb_sig_halt_port;

    localparam int          DEPTH = 8;
    localparam logic [31:0] SIGA  = 32'h0000_0f00;
    localparam logic [31:0] HALTA = 32'hcafe_beef;
    localparam int MRun = 0, MDrain = 1, MHalted = 2;

    logic        clk_i, rst_ni, wr_ni, sig_ready_i, sig_valid_o, ovf_o, halted_o;
    logic [31:0] addr_i, wdata_i, sig_data_o;
    logic [3:0]  count_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_fifo[$];
    logic [31:0] exp_q[$];
    int          m_mode;
    bit          m_ovf;

    sig_halt_port dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .wr_ni       (wr_ni),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .sig_valid_o (sig_valid_o),
        .sig_ready_i (sig_ready_i),
        .sig_data_o  (sig_data_o),
        .count_o     (count_o),
        .ovf_o       (ovf_o),
        .halted_o    (halted_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Handshake happens at the next rising edge; head must be the oldest accepted word.
    always @(negedge clk_i) begin
        if (rst_ni && sig_valid_o && sig_ready_i) begin
            if (exp_q.size() == 0) begin
                chk("spurious_valid", 32'(sig_valid_o), 32'd0);
            end else begin
                chk("sig_data_order", sig_data_o, exp_q.pop_front());
            end
        end
    end

    task automatic model_clear();
        m_fifo.delete();
        exp_q.delete();
        m_mode = MRun;
        m_ovf  = 1'b0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_valid", 32'(sig_valid_o), 32'd0);
        chk("rst_data", sig_data_o, 32'd0);
        chk("rst_ovf", 32'(ovf_o), 32'd0);
        chk("rst_halted", 32'(halted_o), 32'd0);
    endtask

    // Entered and left at posedge+1; reset asserted between clock edges.
    task automatic async_reset();
        wr_ni = 1'b1;
        sig_ready_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1 check_reset_outputs();
        model_clear();
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
    endtask

    task automatic step(input logic wr_n, input logic [31:0] a, input logic [31:0] d,
                        input logic rdy);
        bit pop_m, sig_st, halt_st;
        int pre;
        wr_ni = wr_n;
        addr_i = a;
        wdata_i = d;
        sig_ready_i = rdy;
        @(posedge clk_i);
        pre     = m_fifo.size();
        pop_m   = (pre != 0) && rdy;
        sig_st  = !wr_n && (a == SIGA);
        halt_st = !wr_n && (a == HALTA);
        if (pop_m) void'(m_fifo.pop_front());
        if (sig_st && m_mode == MRun) begin
            if (pre < DEPTH || pop_m) begin
                m_fifo.push_back(d);
                exp_q.push_back(d);
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (m_mode == MDrain && pre == 0) m_mode = MHalted;
        else if (m_mode == MRun && halt_st) m_mode = MDrain;
        #1;
        chk("count", 32'(count_o), 32'(m_fifo.size()));
        chk("sig_valid", 32'(sig_valid_o), 32'(m_fifo.size() != 0));
        chk("ovf", 32'(ovf_o), 32'(m_ovf));
        chk("halted", 32'(halted_o), 32'(m_mode == MHalted));
        if (m_fifo.size() != 0) chk("sig_head", sig_data_o, m_fifo[0]);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b1, 32'h0, 32'h0, rdy);
    endtask

    initial begin
        logic [31:0] a, d;
        int r;
        rst_ni = 1'b0;
        wr_ni = 1'b1;
        addr_i = '0;
        wdata_i = '0;
        sig_ready_i = 1'b0;
        model_clear();
        @(posedge clk_i);
        #1 check_reset_outputs();
        rst_ni = 1'b1;

        // Basic stream
        step(1'b0, SIGA, 32'h1111_1111, 1'b1);
        step(1'b0, SIGA, 32'h2222_2222, 1'b1);
        step(1'b0, SIGA, 32'h3333_3333, 1'b1);
        idle(3, 1'b1);
        chk("basic_drained", 32'(exp_q.size()), 32'd0);

        // Backpressure and overflow: word 8 is lost
        for (int i = 0; i < 9; i++) step(1'b0, SIGA, 32'(i), 1'b0);
        chk("bp_count", 32'(count_o), 32'd8);
        chk("bp_ovf", 32'(ovf_o), 32'd1);
        idle(10, 1'b1);
        chk("bp_drained", 32'(exp_q.size()), 32'd0);

        // Full with simultaneous push+pop
        async_reset();
        for (int i = 0; i < 8; i++) step(1'b0, SIGA, 32'h100 + 32'(i), 1'b0);
        step(1'b0, SIGA, 32'h0000_00aa, 1'b1);
        chk("full_pp_count", 32'(count_o), 32'd8);
        chk("full_pp_ovf", 32'(ovf_o), 32'd0);
        idle(10, 1'b1);
        chk("full_pp_drained", 32'(exp_q.size()), 32'd0);

        // Drain then halt; store during DRAIN ignored
        async_reset();
        for (int i = 0; i < 3; i++) step(1'b0, SIGA, 32'h5000 + 32'(i), 1'b0);
        step(1'b0, HALTA, 32'h0, 1'b0);
        step(1'b0, SIGA, 32'hdead_0001, 1'b0);
        chk("drain_ignored_count", 32'(count_o), 32'd3);
        idle(6, 1'b1);
        chk("drain_halted", 32'(halted_o), 32'd1);

        // Empty halt: two cycles to HALTED, then sticky
        async_reset();
        step(1'b0, HALTA, 32'h0, 1'b1);
        chk("empty_halt_c1", 32'(halted_o), 32'd0);
        step(1'b1, 32'h0, 32'h0, 1'b1);
        chk("empty_halt_c2", 32'(halted_o), 32'd1);
        for (int i = 0; i < 100; i++) step(1'(($urandom & 3) != 0), SIGA, $urandom, 1'($urandom));

        // Reset mid-drain
        async_reset();
        for (int i = 0; i < 4; i++) step(1'b0, SIGA, 32'h7000 + 32'(i), 1'b0);
        step(1'b0, HALTA, 32'h0, 1'b0);
        idle(1, 1'b0);
        async_reset();
        step(1'b0, SIGA, 32'h0bad_cafe, 1'b1);
        idle(2, 1'b1);
        chk("post_reset_drained", 32'(exp_q.size()), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (i % 300 == 299) async_reset();
            r = int'($urandom_range(0, 63));
            if (r < 40)       a = SIGA;
            else if (r == 63) a = HALTA;
            else              a = $urandom;
            d = $urandom;
            step(1'(($urandom_range(0, 9)) >= 7), a, d, 1'(($urandom_range(0, 2)) != 0));
        end
        idle(DEPTH + 2, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sig_halt_port.md
# sig_halt_port

Memory-mapped signature/halt peripheral on the data-memory store path, alongside the data memory. It captures 32-bit stores to the signature address into a FIFO and streams them out over a valid/ready port, so signature dumping no longer relies on a bench probing internal pipeline signals. A store to the halt address drains the FIFO, then raises a sticky `halted` flag.

## Interface
- `SIG_ADDR`, 32'h0000_0f00, store address whose data is captured as a signature word
- `HALT_ADDR`, 32'hcafe_beef, store address that requests halt
- `DEPTH`, 8, FIFO depth in words; power of two, ≥2
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `wr`  in  1  data-memory write strobe, active-low (0 = store this cycle), same timing as data-memory write
- `addr`  in  32  store address (writeback-stage ALU result)
- `wdata`  in  32  store data
- `sig_valid`  out  1  FIFO head word available
- `sig_ready`  in  1  consumer accepts head word
- `sig_data`  out  32  FIFO head word
- `count`  out  $clog2(DEPTH)+1  words currently held
- `ovf`  out  1  sticky: a signature store was dropped because the FIFO was full
- `halted`  out  1  sticky: halt requested and FIFO fully drained

## Operation
- Push: `wr==0 && addr==SIG_ADDR`, state RUN, and (not full or pop this cycle) → `wdata` written at tail.
- Pop: `sig_valid && sig_ready` → head advances.
- Push and pop in the same cycle are both honoured at every fill level; `count` is unchanged.
- Full and push without pop → word dropped; `ovf` set and held until reset.
- Pointers wrap modulo DEPTH. `count` ranges 0..DEPTH. Full = `count==DEPTH`; empty = `count==0`.
- Stores to any other address are ignored. `wr==1` is never a store.
- FSM states:
  - RUN: halt store (`wr==0 && addr==HALT_ADDR`) → DRAIN.
  - DRAIN: no pushes; signature stores are ignored and do not set `ovf`. Pops continue. `count==0` → HALTED.
  - HALTED: `halted=1`, no pushes; stays until reset.
- A halt store with the FIFO already empty still passes through DRAIN for one cycle.
- `SIG_ADDR==HALT_ADDR` is illegal; the bench need not cover it.
- Reset (async, any state, mid-drain included): state RUN, pointers 0, `count=0`, `sig_valid=0`, `sig_data=0`, `ovf=0`, `halted=0`. Buffered words are discarded.

## Timing
- Push at edge N → `sig_valid=1` and `sig_data` valid after edge N; the consumer sees them in cycle N+1.
- `sig_data` is driven from the FIFO head register or array read; it is combinational in the read pointer only, with no path from `sig_ready`.
- `sig_valid` = `count!=0`; it does not depend on `sig_ready` or on the store inputs.
- Once `sig_valid` is high, `sig_data` is held stable until the handshake completes.
- `halted` rises on the edge after the edge that pops the last word. With an empty FIFO, it rises 2 cycles after the halt store edge (RUN→DRAIN→HALTED).
- `count`, `ovf`, `halted` are registered outputs.

## Structure
- Shared package `sig_pkg`:
  - default `SIG_ADDR`/`HALT_ADDR` constants
  - state enum `sig_state_e {SIG_RUN, SIG_DRAIN, SIG_HALTED}`
- One sub-module, `sync_fifo`, parameterised by WIDTH/DEPTH:
  - push/pop interface with full/empty/count
  - simultaneous push+pop when full is permitted
- Top level: address decode, FSM, `ovf` flag, connection to `sync_fifo`.

## Test plan
- Basic stream:
  - stores 32'h1111_1111, 32'h2222_2222, 32'h3333_3333 to 0xf00 with `sig_ready=1` → same three words in order on `sig_data`, each visible the cycle after its store
  - `count` returns to 0
- Backpressure and overflow:
  - `sig_ready=0`, 9 stores of 0..8 with DEPTH=8 → `count=8`, `ovf=1`, word 8 lost
  - raise `sig_ready` → 0..7 drained in order
- Full with simultaneous push+pop:
  - FIFO full, store 32'hAA with `sig_ready=1` → `count` stays 8, `ovf` stays 0
  - 32'hAA emerges after the 8 earlier words
- Drain then halt:
  - 3 words queued, `sig_ready=0`, halt store to 0xcafebeef, then a store to 0xf00 → that word ignored, `ovf` unchanged
  - release `sig_ready` → 3 words out; `halted=1` one cycle after the last pop
- Empty halt: halt store with FIFO empty → `halted=1` exactly 2 cycles later; stays high for 100 cycles.
- Reset mid-drain:
  - assert `rst=0` asynchronously in DRAIN with 4 words held → outputs immediately 0, `halted=0`
  - after release, a new 0xf00 store streams normally
